// File: rtl/uart_date_parser_if.sv
// Byte-in / date-out bundle between the UART receiver side and the date parser.
interface uart_date_parser_if;
  logic        op_flag;
  logic [7:0]  op_data;
  logic        date_flag;
  logic [15:0] year;
  logic [7:0]  month;
  logic [7:0]  day;
  logic        err_flag;
  logic [1:0]  err_code;

  modport master (
    output op_flag, op_data,
    input  date_flag, year, month, day, err_flag, err_code
  );

  modport slave (
    input  op_flag, op_data,
    output date_flag, year, month, day, err_flag, err_code
  );
endinterface

// File: rtl/uart_date_parser.sv
// Assembles four UART bytes (year hi, year lo, month, day) into a BCD date,
// validates it and publishes it with a one-cycle strobe. Bad or stalled
// frames raise a one-cycle error strobe with a held error code.
module uart_date_parser #(
  parameter logic [15:0] TIMEOUT_CNT_MAX = 16'd8680
) (
  input logic              clk,
  input logic              rst_n,
  uart_date_parser_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_Y_LO = 2'd1,
    S_MON  = 2'd2,
    S_DAY  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_BCD     = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_yh;
  logic [7:0]  r_yl;
  logic [7:0]  r_mon;
  logic [15:0] r_year;
  logic [7:0]  r_month;
  logic [7:0]  r_day;
  logic        r_date_flag;
  logic        r_err_flag;
  logic [1:0]  r_err_code;

  logic        w_tc;
  logic        w_bcd_err;
  logic        w_range_err;

  function automatic logic nib_bad(input logic [7:0] b);
    return (b[7:4] > 4'h9) || (b[3:0] > 4'h9);
  endfunction

  function automatic logic [7:0] day_limit(input logic [7:0] m);
    case (m)
      8'h02:                      return 8'h29;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  // Frame checks on the three shadows plus the day byte arriving this cycle;
  // the counter fires on the cycle it would reach its maximum, so the error
  // strobe lands TIMEOUT_CNT_MAX+1 cycles after the last accepted byte.
  always_comb begin
    w_tc        = (r_state != S_IDLE) && (r_cnt == TIMEOUT_CNT_MAX - 16'd1);
    w_bcd_err   = nib_bad(r_yh) || nib_bad(r_yl) || nib_bad(r_mon) ||
                  nib_bad(bus.op_data);
    w_range_err = (r_mon < 8'h01) || (r_mon > 8'h12) ||
                  (bus.op_data == 8'h00) || (bus.op_data > day_limit(r_mon));
  end

  // Shadow capture of the first three bytes; contents only matter mid-frame.
  always_ff @(posedge clk) begin
    if (bus.op_flag) begin
      case (r_state)
        S_IDLE:  r_yh  <= bus.op_data;
        S_Y_LO:  r_yl  <= bus.op_data;
        S_MON:   r_mon <= bus.op_data;
        default: ;
      endcase
    end
  end

  // Frame FSM with timeout counter and registered date/error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_year      <= 16'h0000;
      r_month     <= 8'h00;
      r_day       <= 8'h00;
      r_date_flag <= 1'b0;
      r_err_flag  <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_date_flag <= 1'b0;
      r_err_flag  <= 1'b0;
      if (r_state == S_IDLE) begin
        r_cnt <= 16'd0;
        if (bus.op_flag) r_state <= S_Y_LO;
      end else if (bus.op_flag) begin
        // A byte always beats a coincident terminal count.
        r_cnt <= 16'd0;
        case (r_state)
          S_Y_LO: r_state <= S_MON;
          S_MON:  r_state <= S_DAY;
          default: begin
            r_state <= S_IDLE;
            if (w_bcd_err) begin
              r_err_flag <= 1'b1;
              r_err_code <= ERR_BCD;
            end else if (w_range_err) begin
              r_err_flag <= 1'b1;
              r_err_code <= ERR_RANGE;
            end else begin
              r_year      <= {r_yh, r_yl};
              r_month     <= r_mon;
              r_day       <= bus.op_data;
              r_date_flag <= 1'b1;
            end
          end
        endcase
      end else if (w_tc) begin
        r_state    <= S_IDLE;
        r_cnt      <= 16'd0;
        r_err_flag <= 1'b1;
        r_err_code <= ERR_TIMEOUT;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign bus.date_flag = r_date_flag;
  assign bus.year      = r_year;
  assign bus.month     = r_month;
  assign bus.day       = r_day;
  assign bus.err_flag  = r_err_flag;
  assign bus.err_code  = r_err_code;

endmodule

// File: tb/tb_uart_date_parser.sv
// Directed bench for uart_date_parser: valid dates, BCD and range errors,
// inter-byte timeout, terminal-count race, mid-frame reset, back-to-back frames.
module tb_uart_date_parser;

  localparam int MAX = 8680;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   n_date_pulses;
  int   n_err_pulses;
  int   n_both;

  uart_date_parser_if u_if ();

  uart_date_parser #(.TIMEOUT_CNT_MAX(16'(MAX))) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counters sampled mid-cycle.
  always @(negedge clk) begin
    if (u_if.date_flag) n_date_pulses++;
    if (u_if.err_flag) n_err_pulses++;
    if (u_if.date_flag && u_if.err_flag) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe is high in the current cycle; returns one cycle later (N+1).
  task automatic send_byte(input logic [7:0] b);
    u_if.op_flag = 1'b1;
    u_if.op_data = b;
    @(posedge clk);
    #1;
    u_if.op_flag = 1'b0;
    u_if.op_data = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] yh, input logic [7:0] yl,
                            input logic [7:0] mo, input logic [7:0] dy,
                            input int gap);
    send_byte(yh); idle(gap - 1);
    send_byte(yl); idle(gap - 1);
    send_byte(mo); idle(gap - 1);
    send_byte(dy);
  endtask

  task automatic chk_date(input string tag, input logic [15:0] y,
                          input logic [7:0] m, input logic [7:0] d);
    chk({tag, "_year"}, 32'(u_if.year), 32'(y));
    chk({tag, "_month"}, 32'(u_if.month), 32'(m));
    chk({tag, "_day"}, 32'(u_if.day), 32'(d));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, e0, early;
    n_vec = 0; n_err = 0;
    n_date_pulses = 0; n_err_pulses = 0; n_both = 0;
    rst_n = 1'b0;
    u_if.op_flag = 1'b0;
    u_if.op_data = 8'h00;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Reset state
    chk("rst_date_flag", 32'(u_if.date_flag), 0);
    chk("rst_err_flag", 32'(u_if.err_flag), 0);
    chk("rst_err_code", 32'(u_if.err_code), 0);
    chk_date("rst", 16'h0000, 8'h00, 8'h00);

    // Slow valid frame 2000/10/29
    d0 = n_date_pulses; e0 = n_err_pulses;
    send_frame(8'h20, 8'h00, 8'h10, 8'h29, 4340);
    chk("f1_date_flag", 32'(u_if.date_flag), 1);
    chk("f1_err_flag", 32'(u_if.err_flag), 0);
    chk_date("f1", 16'h2000, 8'h10, 8'h29);
    idle(1);
    chk("f1_date_flag_drop", 32'(u_if.date_flag), 0);
    chk("f1_date_pulses", 32'(n_date_pulses - d0), 1);
    chk("f1_err_pulses", 32'(n_err_pulses - e0), 0);

    // Feb 30 rejected, outputs held
    send_frame(8'h19, 8'h99, 8'h02, 8'h30, 2);
    chk("feb30_err_flag", 32'(u_if.err_flag), 1);
    chk("feb30_date_flag", 32'(u_if.date_flag), 0);
    chk("feb30_err_code", 32'(u_if.err_code), 2);
    chk_date("feb30", 16'h2000, 8'h10, 8'h29);
    idle(1);

    // Feb 29 accepted
    send_frame(8'h19, 8'h99, 8'h02, 8'h29, 2);
    chk("feb29_date_flag", 32'(u_if.date_flag), 1);
    chk_date("feb29", 16'h1999, 8'h02, 8'h29);
    idle(1);

    // Non-BCD nibble
    send_frame(8'h20, 8'h0A, 8'h10, 8'h29, 1);
    chk("bcd_err_flag", 32'(u_if.err_flag), 1);
    chk("bcd_err_code", 32'(u_if.err_code), 1);
    idle(1);

    // BCD check outranks range check (month 13 and bad nibble in day)
    send_frame(8'h20, 8'h00, 8'h13, 8'h2F, 1);
    chk("prio_err_code", 32'(u_if.err_code), 1);
    idle(1);

    // Month out of range
    send_frame(8'h20, 8'h00, 8'h13, 8'h29, 1);
    chk("mon13_err_flag", 32'(u_if.err_flag), 1);
    chk("mon13_err_code", 32'(u_if.err_code), 2);
    idle(1);
    chk("mon13_code_held", 32'(u_if.err_code), 2);
    chk("mon13_flag_drop", 32'(u_if.err_flag), 0);

    // Day zero and day 31 in a 30-day month
    send_frame(8'h20, 8'h00, 8'h05, 8'h00, 1);
    chk("day0_err_flag", 32'(u_if.err_flag), 1);
    idle(1);
    send_frame(8'h20, 8'h00, 8'h11, 8'h31, 1);
    chk("nov31_err_flag", 32'(u_if.err_flag), 1);
    chk_date("nov31", 16'h1999, 8'h02, 8'h29);
    idle(1);

    // Timeout after two bytes: strobe at T, error at exactly T+MAX+1
    send_byte(8'h20);
    send_byte(8'h00);
    early = 0;
    for (int i = 1; i <= MAX; i++) begin
      if (u_if.err_flag) early++;
      idle(1);
    end
    chk("to_early", 32'(early), 0);
    chk("to_err_flag", 32'(u_if.err_flag), 1);
    chk("to_err_code", 32'(u_if.err_code), 3);
    idle(1);
    chk("to_flag_drop", 32'(u_if.err_flag), 0);
    send_frame(8'h20, 8'h00, 8'h04, 8'h30, 2);
    chk("after_to_date_flag", 32'(u_if.date_flag), 1);
    chk_date("after_to", 16'h2000, 8'h04, 8'h30);
    idle(1);

    // Third byte exactly on the terminal-count cycle
    e0 = n_err_pulses;
    send_byte(8'h21);
    send_byte(8'h00);
    idle(MAX - 1);
    send_byte(8'h05);
    send_byte(8'h31);
    chk("tc_date_flag", 32'(u_if.date_flag), 1);
    chk("tc_err_pulses", 32'(n_err_pulses - e0), 0);
    chk_date("tc", 16'h2100, 8'h05, 8'h31);
    idle(1);

    // Reset mid-frame, with strobes ignored while reset is low
    send_byte(8'h20);
    send_byte(8'h00);
    rst_n = 1'b0;
    #2;
    chk_date("mid_rst", 16'h0000, 8'h00, 8'h00);
    chk("mid_rst_code", 32'(u_if.err_code), 0);
    u_if.op_flag = 1'b1;
    u_if.op_data = 8'h12;
    idle(2);
    u_if.op_flag = 1'b0;
    rst_n = 1'b1;
    idle(1);
    d0 = n_date_pulses; e0 = n_err_pulses;
    send_frame(8'h20, 8'h12, 8'h12, 8'h31, 2);
    chk("post_rst_date_flag", 32'(u_if.date_flag), 1);
    chk_date("post_rst", 16'h2012, 8'h12, 8'h31);
    idle(1);
    chk("post_rst_err_pulses", 32'(n_err_pulses - e0), 0);

    // Back-to-back frames with no dead cycle
    d0 = n_date_pulses;
    send_frame(8'h19, 8'h00, 8'h01, 8'h01, 1);
    chk("b2b1_date_flag", 32'(u_if.date_flag), 1);
    chk_date("b2b1", 16'h1900, 8'h01, 8'h01);
    send_frame(8'h20, 8'h24, 8'h06, 8'h30, 1);
    chk("b2b2_date_flag", 32'(u_if.date_flag), 1);
    chk_date("b2b2", 16'h2024, 8'h06, 8'h30);
    idle(2);
    chk("b2b_pulses", 32'(n_date_pulses - d0), 2);
    chk("never_both", 32'(n_both), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
